// File: rtl/alu_result_collector_if.sv
// Bundle of ALU result inputs and the buffered valid/ready result port
// seen by alu_result_collector. The collector uses the slave view; the
// environment that drives the ALU results and consumes the output uses
// the master view.
interface alu_result_collector_if #(
  parameter int width = 16,
  parameter int DEPTH = 8
);
  logic [2*width-1:0]       Arith_OUT;
  logic                     Carry_OUT;
  logic                     Arith_Flag;
  logic [width-1:0]         Logic_OUT;
  logic                     Logic_Flag;
  logic [width-1:0]         CMP_OUT;
  logic                     CMP_Flag;
  logic [width:0]           SHIFT_OUT;
  logic                     SHIFT_Flag;
  logic                     CLR;
  logic [2*width-1:0]       RES_DATA;
  logic [1:0]               RES_TAG;
  logic                     RES_CARRY;
  logic                     RES_VALID;
  logic                     RES_READY;
  logic [$clog2(DEPTH):0]   COUNT;
  logic                     OVERFLOW;
  logic                     MULTI_ERR;

  modport master (
    output Arith_OUT, Carry_OUT, Arith_Flag,
    output Logic_OUT, Logic_Flag,
    output CMP_OUT, CMP_Flag,
    output SHIFT_OUT, SHIFT_Flag,
    output CLR, RES_READY,
    input  RES_DATA, RES_TAG, RES_CARRY, RES_VALID,
    input  COUNT, OVERFLOW, MULTI_ERR
  );

  modport slave (
    input  Arith_OUT, Carry_OUT, Arith_Flag,
    input  Logic_OUT, Logic_Flag,
    input  CMP_OUT, CMP_Flag,
    input  SHIFT_OUT, SHIFT_Flag,
    input  CLR, RES_READY,
    output RES_DATA, RES_TAG, RES_CARRY, RES_VALID,
    output COUNT, OVERFLOW, MULTI_ERR
  );
endinterface

// File: rtl/alu_result_collector.sv
// Collects the per-unit ALU results, tags each one with its source unit,
// widens it to 2*width bits and queues it in a small FIFO whose head is
// presented on registered valid/ready outputs. Only one result per cycle
// is accepted (Arith > Logic > CMP > Shift); losers and dropped pushes are
// recorded in sticky error flags.
module alu_result_collector #(
  parameter int width = 16,
  parameter int DEPTH = 8
) (
  input logic                  CLK,
  input logic                  RST,
  alu_result_collector_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = 2 * width;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  localparam logic [1:0] TAG_ARITH = 2'b00;
  localparam logic [1:0] TAG_LOGIC = 2'b01;
  localparam logic [1:0] TAG_CMP   = 2'b10;
  localparam logic [1:0] TAG_SHIFT = 2'b11;

  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [1:0]        mem_tag   [DEPTH];
  logic              mem_carry [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;

  logic              push_req, multi_req;
  logic              full, pop, push_ok, drop;

  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_tag;
  logic              in_carry;

  logic [DATA_W-1:0] head_data;
  logic [1:0]        head_tag;
  logic              head_carry;

  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_tag;
  logic              out_carry;
  logic              out_valid;
  logic              overflow, multi_err;

  assign push_req  = bus.Arith_Flag | bus.Logic_Flag | bus.CMP_Flag | bus.SHIFT_Flag;
  assign multi_req = (bus.Arith_Flag & (bus.Logic_Flag | bus.CMP_Flag | bus.SHIFT_Flag))
                   | (bus.Logic_Flag & (bus.CMP_Flag | bus.SHIFT_Flag))
                   | (bus.CMP_Flag & bus.SHIFT_Flag);

  // Pick the highest-priority flagged unit and widen its result to the tagged entry format
  always_comb begin
    in_data  = '0;
    in_tag   = TAG_ARITH;
    in_carry = 1'b0;
    if (bus.Arith_Flag) begin
      in_data  = bus.Arith_OUT;
      in_carry = bus.Carry_OUT;
    end else if (bus.Logic_Flag) begin
      in_data = {{width{1'b0}}, bus.Logic_OUT};
      in_tag  = TAG_LOGIC;
    end else if (bus.CMP_Flag) begin
      in_data = {{width{1'b0}}, bus.CMP_OUT};
      in_tag  = TAG_CMP;
    end else if (bus.SHIFT_Flag) begin
      in_data = {{(width-1){1'b0}}, bus.SHIFT_OUT};
      in_tag  = TAG_SHIFT;
    end
  end

  // Decide push/pop/drop for this edge and the resulting pointers, occupancy and head entry
  always_comb begin
    full        = (count == FULL_COUNT);
    pop         = out_valid & bus.RES_READY & ~bus.CLR;
    push_ok     = push_req & ~bus.CLR & (~full | pop);
    drop        = push_req & ~bus.CLR & full & ~pop;
    count_next  = count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (bus.CLR) begin
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_next = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count_next = count + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count_next = count - CNT_W'(1);
      end
    end
    if (push_ok && (wr_ptr == rd_ptr_next)) begin
      head_data  = in_data;
      head_tag   = in_tag;
      head_carry = in_carry;
    end else begin
      head_data  = mem_data[rd_ptr_next];
      head_tag   = mem_tag[rd_ptr_next];
      head_carry = mem_carry[rd_ptr_next];
    end
  end

  // Write an accepted entry at the tail; storage needs no reset
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem_data[wr_ptr]  <= in_data;
      mem_tag[wr_ptr]   <= in_tag;
      mem_carry[wr_ptr] <= in_carry;
    end
  end

  // Advance FIFO state, register the head entry and accumulate sticky errors
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_carry <= 1'b0;
      overflow  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      if (count_next != '0) begin
        out_data  <= head_data;
        out_tag   <= head_tag;
        out_carry <= head_carry;
      end
      if (bus.CLR) begin
        overflow  <= 1'b0;
        multi_err <= 1'b0;
      end else begin
        overflow  <= overflow | drop;
        multi_err <= multi_err | multi_req;
      end
    end
  end

  assign bus.RES_DATA  = out_data;
  assign bus.RES_TAG   = out_tag;
  assign bus.RES_CARRY = out_carry;
  assign bus.RES_VALID = out_valid;
  assign bus.COUNT     = count;
  assign bus.OVERFLOW  = overflow;
  assign bus.MULTI_ERR = multi_err;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench for alu_result_collector: directed scenarios plus
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_result_collector;
  localparam int width = 16;
  localparam int DEPTH = 4;
  localparam int DW    = 2 * width;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  alu_result_collector_if #(.width(width), .DEPTH(DEPTH)) bus ();

  alu_result_collector #(.width(width), .DEPTH(DEPTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    tag;
    logic          carry;
  } entry_t;

  entry_t model_q[$];
  entry_t model_out;
  logic   model_overflow;
  logic   model_multi;

  int compare_count  = 0;
  int mismatch_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_out      = '0;
    model_overflow = 1'b0;
    model_multi    = 1'b0;
  endtask

  // Reference behaviour at one clock edge, from the current inputs
  task automatic modelStep();
    entry_t e;
    int     flags;
    logic   was_full;
    logic   popped;
    if (bus.CLR) begin
      model_q.delete();
      model_overflow = 1'b0;
      model_multi    = 1'b0;
    end else begin
      flags    = int'(bus.Arith_Flag) + int'(bus.Logic_Flag) + int'(bus.CMP_Flag) + int'(bus.SHIFT_Flag);
      was_full = (model_q.size() == DEPTH);
      popped   = (model_q.size() != 0) && bus.RES_READY;
      if (flags > 1) model_multi = 1'b1;
      if (popped) void'(model_q.pop_front());
      if (flags > 0) begin
        e = '0;
        if (bus.Arith_Flag) begin
          e.data = bus.Arith_OUT;  e.tag = 2'd0; e.carry = bus.Carry_OUT;
        end else if (bus.Logic_Flag) begin
          e.data = DW'(bus.Logic_OUT); e.tag = 2'd1;
        end else if (bus.CMP_Flag) begin
          e.data = DW'(bus.CMP_OUT); e.tag = 2'd2;
        end else begin
          e.data = DW'(bus.SHIFT_OUT); e.tag = 2'd3;
        end
        if (!was_full || popped) model_q.push_back(e);
        else model_overflow = 1'b1;
      end
    end
    if (model_q.size() != 0) model_out = model_q[0];
  endtask

  task automatic checkAll();
    checkOutput("valid",    64'(bus.RES_VALID), 64'(model_q.size() != 0));
    checkOutput("count",    64'(bus.COUNT),     64'(model_q.size()));
    checkOutput("data",     64'(bus.RES_DATA),  64'(model_out.data));
    checkOutput("tag",      64'(bus.RES_TAG),   64'(model_out.tag));
    checkOutput("carry",    64'(bus.RES_CARRY), 64'(model_out.carry));
    checkOutput("overflow", 64'(bus.OVERFLOW),  64'(model_overflow));
    checkOutput("multi",    64'(bus.MULTI_ERR), 64'(model_multi));
  endtask

  task automatic idleInputs();
    bus.Arith_Flag = 1'b0;
    bus.Logic_Flag = 1'b0;
    bus.CMP_Flag   = 1'b0;
    bus.SHIFT_Flag = 1'b0;
    bus.CLR        = 1'b0;
  endtask

  // One clock: inputs are already set; sample at the edge, then check 1 time unit later
  task automatic applyStimulus();
    @(posedge CLK);
    modelStep();
    #1;
    checkAll();
    idleInputs();
  endtask

  initial begin
    bus.Arith_OUT  = '0;
    bus.Carry_OUT  = 1'b0;
    bus.Logic_OUT  = '0;
    bus.CMP_OUT    = '0;
    bus.SHIFT_OUT  = '0;
    bus.RES_READY  = 1'b0;
    idleInputs();
    modelReset();

    // Reset and idle
    RST = 1'b0;
    #12;
    checkAll();
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus();

    // Single logic result, held while not ready
    bus.Logic_Flag = 1'b1;
    bus.Logic_OUT  = 16'hA5A5;
    applyStimulus();
    checkOutput("logic_data", 64'(bus.RES_DATA), 64'h0000A5A5);
    checkOutput("logic_tag",  64'(bus.RES_TAG),  64'd1);
    for (int i = 0; i < 3; i++) applyStimulus();
    checkOutput("logic_hold", 64'(bus.RES_DATA), 64'h0000A5A5);
    bus.RES_READY = 1'b1;
    applyStimulus();
    checkOutput("logic_popped", 64'(bus.RES_VALID), 64'd0);

    // Order and pointer wrap with a ready consumer
    for (int r = 0; r < 3; r++) begin
      bus.Arith_Flag = 1'b1; bus.Arith_OUT = 32'h0001_0000; bus.Carry_OUT = 1'b1;
      applyStimulus();
      checkOutput("wrap_arith_data",  64'(bus.RES_DATA),  64'h00010000);
      checkOutput("wrap_arith_carry", 64'(bus.RES_CARRY), 64'd1);
      bus.CMP_Flag = 1'b1; bus.CMP_OUT = 16'h0003;
      applyStimulus();
      checkOutput("wrap_cmp_tag", 64'(bus.RES_TAG), 64'd2);
      bus.SHIFT_Flag = 1'b1; bus.SHIFT_OUT = 17'h1_8000;
      applyStimulus();
      checkOutput("wrap_shift_data", 64'(bus.RES_DATA), 64'h00018000);
      checkOutput("wrap_shift_tag",  64'(bus.RES_TAG),  64'd3);
      applyStimulus();
    end

    // Overflow at full, then drain
    bus.RES_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.Arith_Flag = 1'b1; bus.Arith_OUT = 32'(100 + i); bus.Carry_OUT = i[0];
      applyStimulus();
    end
    checkOutput("ovf_count", 64'(bus.COUNT),    64'd4);
    checkOutput("ovf_flag",  64'(bus.OVERFLOW), 64'd1);
    bus.RES_READY = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();

    // Push with simultaneous pop at full is accepted
    bus.CLR = 1'b1;
    applyStimulus();
    bus.RES_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.Logic_Flag = 1'b1; bus.Logic_OUT = 16'(16'h1000 + i);
      applyStimulus();
    end
    bus.RES_READY = 1'b1;
    bus.CMP_Flag = 1'b1; bus.CMP_OUT = 16'hBEEF;
    applyStimulus();
    checkOutput("full_pp_count", 64'(bus.COUNT),    64'd4);
    checkOutput("full_pp_ovf",   64'(bus.OVERFLOW), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus();

    // Multi-flag then CLR
    bus.RES_READY = 1'b0;
    bus.Arith_Flag = 1'b1; bus.Arith_OUT = 32'hDEAD_0001; bus.Carry_OUT = 1'b0;
    bus.SHIFT_Flag = 1'b1; bus.SHIFT_OUT = 17'h0_1234;
    applyStimulus();
    checkOutput("multi_tag",   64'(bus.RES_TAG),   64'd0);
    checkOutput("multi_err",   64'(bus.MULTI_ERR), 64'd1);
    checkOutput("multi_count", 64'(bus.COUNT),     64'd1);
    applyStimulus();
    bus.CLR = 1'b1;
    bus.Logic_Flag = 1'b1; bus.Logic_OUT = 16'h7777;
    applyStimulus();
    checkOutput("clr_multi", 64'(bus.MULTI_ERR), 64'd0);
    checkOutput("clr_count", 64'(bus.COUNT),     64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.Arith_Flag = ($urandom_range(0, 3) == 0);
      bus.Logic_Flag = ($urandom_range(0, 3) == 0);
      bus.CMP_Flag   = ($urandom_range(0, 3) == 0);
      bus.SHIFT_Flag = ($urandom_range(0, 3) == 0);
      bus.Arith_OUT  = $urandom;
      bus.Carry_OUT  = 1'($urandom);
      bus.Logic_OUT  = 16'($urandom);
      bus.CMP_OUT    = 16'($urandom);
      bus.SHIFT_OUT  = 17'($urandom);
      bus.RES_READY  = 1'($urandom);
      bus.CLR        = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    // Asynchronous reset with three entries queued
    bus.CLR = 1'b1;
    bus.RES_READY = 1'b0;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      bus.Logic_Flag = 1'b1; bus.Logic_OUT = 16'(16'h0040 + i);
      applyStimulus();
    end
    checkOutput("pre_reset_count", 64'(bus.COUNT), 64'd3);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async_count", 64'(bus.COUNT),     64'd0);
    checkOutput("async_valid", 64'(bus.RES_VALID), 64'd0);
    checkOutput("async_data",  64'(bus.RES_DATA),  64'd0);
    modelReset();
    checkAll();
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus();
    bus.CMP_Flag = 1'b1; bus.CMP_OUT = 16'h00C3;
    applyStimulus();
    applyStimulus();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
